// File: rtl/ultra_pkg.sv
// Shared types and constants for the ultrasonic ranger array controller.
package ultra_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_COUNT,
    S_CALC,
    S_HOLDOFF
  } ultra_state_t;

  // cm ~= us / 58 computed as (us * 1130) >> 16
  localparam int CM_MULT  = 1130;
  localparam int CM_SHIFT = 16;

  function automatic int us_to_cyc(input int f_clk, input int us);
    return us * (f_clk / 1_000_000);
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CYC clocks, phase reset by restart.
module us_tick_gen #(
  parameter int CYC = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [W-1:0] LAST = W'(CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  // Tick is decoded from the count only, so restart never loops back into it.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/ultrasonic_array_ctrl.sv
// Round-robin HC-SR04 array driver: trigger, time the echo in us, convert to cm.
module ultrasonic_array_ctrl
  import ultra_pkg::*;
#(
  parameter int F_CLK      = 50_000_000,
  parameter int N_CH       = 4,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30_000,
  parameter int HOLDOFF_US = 60_000,
  parameter int DIST_W     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     enable,
  input  logic [N_CH-1:0]                          echo,
  input  logic [DIST_W-1:0]                        near_thresh,
  output logic [N_CH-1:0]                          trig,
  output logic                                     busy,
  output logic                                     dist_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] dist_ch,
  output logic [DIST_W-1:0]                        dist_cm,
  output logic                                     dist_timeout,
  output logic [N_CH-1:0]                          near
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int US_CYC = us_to_cyc(F_CLK, 1);
  localparam int UC_MAX = (TIMEOUT_US > HOLDOFF_US)
                          ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                          : ((HOLDOFF_US > TRIG_US) ? HOLDOFF_US : TRIG_US);
  localparam int UC_W   = $clog2(UC_MAX + 1);
  localparam int PW     = (UC_W + 11 > CM_SHIFT + DIST_W + 1) ? UC_W + 11
                                                               : CM_SHIFT + DIST_W + 1;

  localparam logic [UC_W-1:0] TRIG_LAST = UC_W'(TRIG_US - 1);
  localparam logic [UC_W-1:0] TO_LAST   = UC_W'(TIMEOUT_US - 1);
  localparam logic [UC_W-1:0] HO_LAST   = UC_W'(HOLDOFF_US - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);

  ultra_state_t    state, state_next;
  logic [CH_W-1:0] ch;
  logic [UC_W-1:0] us_cnt;
  logic            tick, restart;
  logic            to_flag, to_set;
  logic [N_CH-1:0] rise, fall;

  // 2-FF synchroniser plus one registered edge-detect stage per channel
  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    logic s1, s2, s3, rise_r, fall_r;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        s3     <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        s1     <= echo[i];
        s2     <= s1;
        s3     <= s2;
        rise_r <= s2 & ~s3;
        fall_r <= ~s2 & s3;
      end
    end
    assign rise[i] = rise_r;
    assign fall[i] = fall_r;
  end

  us_tick_gen #(.CYC(US_CYC)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  assign restart = (state_next != state);

  always_comb begin
    state_next = state;
    to_set     = 1'b0;
    case (state)
      S_IDLE:      if (enable) state_next = S_TRIG;
      S_TRIG:      if (tick && us_cnt == TRIG_LAST) state_next = S_WAIT_ECHO;
      S_WAIT_ECHO: begin
        if (rise[ch]) state_next = S_COUNT;
        else if (tick && us_cnt == TO_LAST) begin
          to_set     = 1'b1;
          state_next = S_CALC;
        end
      end
      S_COUNT: begin
        if (fall[ch]) state_next = S_CALC;
        else if (tick && us_cnt == TO_LAST) begin
          to_set     = 1'b1;
          state_next = S_CALC;
        end
      end
      S_CALC:      state_next = S_HOLDOFF;
      S_HOLDOFF:   if (tick && us_cnt == HO_LAST) state_next = enable ? S_TRIG : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // The measured width must survive into CALC, so that entry does not clear it.
  always_ff @(posedge clk) begin
    if (!rst_n)                               us_cnt <= '0;
    else if (restart && state_next != S_CALC) us_cnt <= '0;
    else if (tick && state != S_IDLE)         us_cnt <= us_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                         ch <= '0;
    else if (state == S_HOLDOFF && state_next != S_HOLDOFF)
      ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)               to_flag <= 1'b0;
    else if (state == S_TRIG) to_flag <= 1'b0;
    else if (to_set)          to_flag <= 1'b1;
  end

  logic [PW-1:0]     prod, quo;
  logic [DIST_W-1:0] cm_calc;

  always_comb begin
    prod    = PW'(us_cnt) * PW'(CM_MULT);
    quo     = prod >> CM_SHIFT;
    cm_calc = (|quo[PW-1:DIST_W]) ? '1 : quo[DIST_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dist_valid   <= 1'b0;
      dist_ch      <= '0;
      dist_cm      <= '0;
      dist_timeout <= 1'b0;
      near         <= '0;
    end else begin
      dist_valid <= (state == S_CALC);
      if (state == S_CALC) begin
        dist_ch      <= ch;
        dist_timeout <= to_flag;
        dist_cm      <= to_flag ? '1 : cm_calc;
        near[ch]     <= !to_flag && (cm_calc < near_thresh);
      end
    end
  end

  always_comb begin
    trig = '0;
    if (state == S_TRIG) trig[ch] = 1'b1;
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/ultrasonic_array_ctrl.md
# ultrasonic_array_ctrl

Parametrised multi-channel driver for HC-SR04-class ultrasonic rangers. It fires N_CH sensors one at a time in round-robin order and measures each echo pulse in microseconds. Each measurement is converted to centimetres with a fixed-point multiply and reported through a one-cycle valid strobe, with a per-channel proximity flag. Missing or stuck echoes end in a bounded timeout instead of hanging the FSM. The block sits between the board echo/trigger pins and the obstacle-avoidance logic.

## Interface
- F_CLK, 50_000_000, clock frequency in Hz
- N_CH, 4, number of sensor channels (1..8)
- TRIG_US, 10, trigger pulse width in µs
- TIMEOUT_US, 30_000, maximum wait for echo rise, and maximum echo width
- HOLDOFF_US, 60_000, quiet gap after each measurement, before the next channel fires
- DIST_W, 16, distance output width
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- enable  in  1  allow new measurements
- echo  in  N_CH  raw echo pins, asynchronous
- near_thresh  in  DIST_W  proximity threshold in cm
- trig  out  N_CH  trigger pins; one-hot or zero
- busy  out  1  high in every state except IDLE
- dist_valid  out  1  one-cycle result strobe
- dist_ch  out  CH_W  channel of the current result; CH_W = max(1, $clog2(N_CH))
- dist_cm  out  DIST_W  distance in cm; all-ones on timeout
- dist_timeout  out  1  the current result timed out
- near  out  N_CH  per-channel latched flag: last valid distance < near_thresh

## Operation
- Synchronisation: each echo bit passes through a 2-FF synchroniser. Edges are detected on the synchronised copy.
- µs tick: US_CYC = F_CLK/1_000_000. The prescaler restarts on every state entry.
- FSM states: IDLE, TRIG, WAIT_ECHO, COUNT, CALC, HOLDOFF.
- IDLE: when enable=1, go to TRIG on the channel pointer ch (reset value 0).
- TRIG: trig[ch]=1 for exactly TRIG_US*US_CYC cycles, then go to WAIT_ECHO.
- WAIT_ECHO: a synchronised rising edge on echo[ch] clears the µs counter and moves to COUNT. If TIMEOUT_US elapses with no rising edge, set the timeout flag and go to CALC.
- COUNT: the µs counter increments per tick.
  - A falling edge goes to CALC.
  - If the counter reaches TIMEOUT_US, set the timeout flag and go to CALC.
- CALC (1 cycle):
  - cm = (us * 1130) >> 16, which approximates us/58.
  - Saturate cm to 2^DIST_W−1.
  - On timeout, the result is all-ones.
- HOLDOFF: wait HOLDOFF_US, then advance ch (N_CH−1 wraps to 0). Go to TRIG if enable=1, else IDLE.
- Echo activity on channels other than ch is ignored.
- Echo already high on entry to WAIT_ECHO does not count; only a rising edge does.
- near[ch] is updated with every result:
  - non-timeout result: set to (cm < near_thresh);
  - timeout: cleared.
  - Other near bits hold their value.
- enable deasserted mid-measurement: the current channel completes, including HOLDOFF, then the FSM returns to IDLE.

## Timing
- Reset (rst_n=0 at a clk edge):
  - FSM to IDLE, ch=0.
  - trig=0, busy=0, dist_valid=0, dist_ch=0, dist_cm=0, dist_timeout=0, near=0.
  - All counters cleared.
  - Reset in any state aborts immediately; trig drops on the next edge.
- Reset wins over any simultaneous event.
- Echo-edge latency: 2 synchroniser cycles plus 1 edge-detect cycle.
- dist_valid, dist_ch, dist_cm, dist_timeout and near are registered together.
  - dist_valid is high for exactly one cycle, the cycle after CALC, which is the first HOLDOFF cycle.
  - dist_ch, dist_cm and dist_timeout hold until the next result.
- Arithmetic:
  - The µs counter is ≥ $clog2(TIMEOUT_US+1) bits.
  - The product is ≥ that width + 11 bits, so it never overflows before the shift.
- Measured width resolution: ±1 µs plus synchroniser skew.

## Structure
- Package `ultra_pkg` holds:
  - the state enum `ultra_state_t`;
  - constants `CM_MULT=1130` and `CM_SHIFT=16`;
  - the helper function `us_to_cyc`.
- Sub-module `us_tick_gen` provides the parametrised prescaler, with a restart input and a 1-cycle tick output.
- The echo synchronisers and edge detectors stay inline, in a generate loop over N_CH.

## Test plan
- N_CH=4, echo[0] rises 100 µs after trig and stays high 580 µs -> trig[0] is exactly 500 cycles; dist_valid once; dist_ch=0, dist_cm=10, dist_timeout=0.
- Echo width 5800 µs on channel 2 -> dist_cm=100. With near_thresh=150: near[2]=1 and the other near bits are unchanged.
- No echo on channel 1 -> dist_valid after TIMEOUT_US; dist_cm=16'hFFFF, dist_timeout=1, near[1]=0.
- Echo stuck high for 40 ms -> timeout at 30 000 µs in COUNT; dist_cm=16'hFFFF; the FSM proceeds to HOLDOFF.
- enable held high over 5 measurements -> dist_ch sequence 0,1,2,3,0; trig never overlaps; spacing between triggers ≥ HOLDOFF_US.
- rst_n=0 during COUNT on channel 3 -> next cycle: trig=0, busy=0, near=0. After release with enable=1, the next trigger is on channel 0.
